rpi_bus_banked_memory: RTL and testbench

- Peripheral-side memory map directly downstream of the half-duplex RPi bus interface.
- Consumes per-bank write strobes, the latched address word and the assembled write data word; returns a registered read_data_word.
- Three live banks: a RAM, control/status registers and a streaming FIFO. The fourth bank is unmapped.
- Sits between the bus interface and application logic; application logic sees fifo status ports.

---
 rtl/rpi_bus_banked_memory_pkg.sv | 28 ++
 rtl/rpi_bus_sync_fifo.sv | 76 +++++++
 rtl/rpi_bus_banked_memory.sv | 157 +++++++++++++++
 tb/tb_rpi_bus_banked_memory.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/rpi_bus_banked_memory_pkg.sv
// Shared constants for the RPi bus banked memory map: bank indices, register offsets,
// control bits, unmapped readback value and status field layout.
package rpi_bus_banked_memory_pkg;

  localparam int unsigned BANK_RAM      = 0;
  localparam int unsigned BANK_REGS     = 1;
  localparam int unsigned BANK_FIFO     = 2;
  localparam int unsigned BANK_UNMAPPED = 3;

  localparam logic [2:0] REG_OFF_SCRATCH     = 3'd0;
  localparam logic [2:0] REG_OFF_CONTROL     = 3'd1;
  localparam logic [2:0] REG_OFF_STATUS      = 3'd2;
  localparam logic [2:0] REG_OFF_WRITE_COUNT = 3'd3;
  localparam logic [2:0] REG_OFF_CHECKSUM    = 3'd4;

  localparam int unsigned CTRL_FIFO_CLEAR_BIT     = 0;
  localparam int unsigned CTRL_CHECKSUM_CLEAR_BIT = 1;

  localparam logic [31:0] UNMAPPED_READBACK = 32'hDEAD_BEEF;

  // Status flags sit directly above the fifo_count field, lowest first.
  localparam int unsigned STATUS_EMPTY_REL     = 0;
  localparam int unsigned STATUS_FULL_REL      = 1;
  localparam int unsigned STATUS_OVERFLOW_REL  = 2;
  localparam int unsigned STATUS_UNDERFLOW_REL = 3;
  localparam int unsigned STATUS_FLAG_COUNT    = 4;

endpackage

// File: rtl/rpi_bus_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with explicit occupancy count, clear, and
// single-cycle overflow/underflow pulses.
module rpi_bus_sync_fifo #(
  parameter int unsigned Width     = 32,
  parameter int unsigned AddrDepth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic                 clear_i,
  input  logic [Width-1:0]     wdata_i,
  output logic [Width-1:0]     head_o,
  output logic [AddrDepth:0]   count_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 overflow_o,
  output logic                 underflow_o
);

  localparam int unsigned Depth = 2 ** AddrDepth;
  localparam logic [AddrDepth:0] FullCount = {1'b1, {AddrDepth{1'b0}}};

  logic [Width-1:0]     mem_q [Depth];
  logic [AddrDepth-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrDepth-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrDepth:0]   count_q, count_d;
  logic                 push_en, pop_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FullCount);
  assign pop_en  = pop_i && !empty_o;
  // A pop frees the slot, so a push into a full FIFO is accepted in the same cycle.
  assign push_en = push_i && (!full_o || pop_en);

  assign overflow_o  = push_i && full_o && !pop_i && !clear_i;
  assign underflow_o = pop_i && empty_o && !clear_i;
  assign head_o      = mem_q[rd_ptr_q];
  assign count_o     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/rpi_bus_banked_memory.sv
// Banked memory map behind the RPi bus interface: RAM, registers, FIFO, unmapped bank.
// Optional RPI_BUS_BANKED_MEMORY_WRITE_CHECKSUM_EN adds a bank-0 write XOR at bank 1 off4.
module rpi_bus_banked_memory
  import rpi_bus_banked_memory_pkg::*;
#(
  parameter int unsigned BUS_WIDTH                  = 16,
  parameter int unsigned TRANSACTIONS_PER_DATA_WORD = 2,
  parameter int unsigned ADDRESS_WIDTH              = 16,
  parameter int unsigned LOG2_OF_NUMBER_OF_BANKS    = 2,
  parameter int unsigned RAM_ADDRESS_DEPTH          = 8,
  parameter int unsigned FIFO_ADDRESS_DEPTH         = 4,
  localparam int unsigned DATA_WIDTH = BUS_WIDTH * TRANSACTIONS_PER_DATA_WORD,
  localparam int unsigned NumBanks   = 2 ** LOG2_OF_NUMBER_OF_BANKS
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NumBanks-1:0]           write_strobe,
  input  logic [DATA_WIDTH-1:0]         write_data_word,
  input  logic [ADDRESS_WIDTH-1:0]      address_word,
  input  logic                          read_complete,
  output logic [DATA_WIDTH-1:0]         read_data_word,
  output logic [FIFO_ADDRESS_DEPTH:0]   fifo_count,
  output logic                          fifo_overflow,
  output logic                          fifo_underflow
);

  localparam int unsigned BankW   = LOG2_OF_NUMBER_OF_BANKS;
  localparam int unsigned StatusW = FIFO_ADDRESS_DEPTH + 1 + STATUS_FLAG_COUNT;
  localparam logic [BankW-1:0] BankRam  = BankW'(BANK_RAM);
  localparam logic [BankW-1:0] BankRegs = BankW'(BANK_REGS);
  localparam logic [BankW-1:0] BankFifo = BankW'(BANK_FIFO);

  logic [BankW-1:0]             bank_sel;
  logic [RAM_ADDRESS_DEPTH-1:0] ram_off;
  logic [2:0]                   reg_off;
  logic                         unused_addr;

  assign bank_sel    = address_word[ADDRESS_WIDTH-1 -: BankW];
  assign ram_off     = address_word[RAM_ADDRESS_DEPTH-1:0];
  assign reg_off     = address_word[2:0];
  assign unused_addr = ^address_word[ADDRESS_WIDTH-BankW-1:RAM_ADDRESS_DEPTH];

  logic ctrl_wr, fifo_clear, fifo_pop;
  assign ctrl_wr    = write_strobe[BANK_REGS] && (reg_off == REG_OFF_CONTROL);
  assign fifo_clear = ctrl_wr && write_data_word[CTRL_FIFO_CLEAR_BIT];
  assign fifo_pop   = read_complete && (bank_sel == BankFifo);

  logic [DATA_WIDTH-1:0]       fifo_head;
  logic                        fifo_full, fifo_empty, ovf_pulse, unf_pulse;
  logic                        overflow_q, underflow_q;

  rpi_bus_sync_fifo #(
    .Width     (DATA_WIDTH),
    .AddrDepth (FIFO_ADDRESS_DEPTH)
  ) u_fifo (
    .clk_i       (clock),
    .rst_ni      (reset),
    .push_i      (write_strobe[BANK_FIFO]),
    .pop_i       (fifo_pop),
    .clear_i     (fifo_clear),
    .wdata_i     (write_data_word),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .overflow_o  (ovf_pulse),
    .underflow_o (unf_pulse)
  );

  assign fifo_overflow  = overflow_q;
  assign fifo_underflow = underflow_q;

  logic [DATA_WIDTH-1:0] ram_q [2 ** RAM_ADDRESS_DEPTH];
  logic [DATA_WIDTH-1:0] scratch_q;
  logic [31:0]           write_count_q;

  always_ff @(posedge clock) begin
    if (write_strobe[BANK_RAM]) ram_q[ram_off] <= write_data_word;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scratch_q     <= '0;
      write_count_q <= '0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      if (write_strobe[BANK_REGS] && (reg_off == REG_OFF_SCRATCH)) scratch_q <= write_data_word;
      if (write_strobe[BANK_RAM]) write_count_q <= write_count_q + 32'd1;
      if (fifo_clear) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end else begin
        overflow_q  <= overflow_q | ovf_pulse;
        underflow_q <= underflow_q | unf_pulse;
      end
    end
  end

`ifdef RPI_BUS_BANKED_MEMORY_WRITE_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      checksum_q <= '0;
    end else if (ctrl_wr && write_data_word[CTRL_CHECKSUM_CLEAR_BIT]) begin
      checksum_q <= '0;
    end else if (write_strobe[BANK_RAM]) begin
      checksum_q <= checksum_q ^ write_data_word;
    end
  end
`endif

  logic [StatusW-1:0]    status;
  logic [DATA_WIDTH-1:0] reg_rdata;

  assign status = {underflow_q, overflow_q, fifo_full, fifo_empty, fifo_count};

  always_comb begin
    reg_rdata = '0;
    case (reg_off)
      REG_OFF_SCRATCH:     reg_rdata = scratch_q;
      REG_OFF_STATUS:      reg_rdata = DATA_WIDTH'(status);
      REG_OFF_WRITE_COUNT: reg_rdata = DATA_WIDTH'(write_count_q);
`ifdef RPI_BUS_BANKED_MEMORY_WRITE_CHECKSUM_EN
      REG_OFF_CHECKSUM:    reg_rdata = checksum_q;
`endif
      default:             reg_rdata = '0;
    endcase
  end

  // Stage 1 captures each bank's read value; stage 2 registers the bank mux.
  logic [DATA_WIDTH-1:0] ram_rdata_q, reg_rdata_q, fifo_rdata_q;
  logic [BankW-1:0]      bank_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ram_rdata_q    <= '0;
      reg_rdata_q    <= '0;
      fifo_rdata_q   <= '0;
      bank_q         <= '0;
      read_data_word <= '0;
    end else begin
      ram_rdata_q  <= ram_q[ram_off];
      reg_rdata_q  <= reg_rdata;
      fifo_rdata_q <= fifo_empty ? '0 : fifo_head;
      bank_q       <= bank_sel;
      case (bank_q)
        BankRam:  read_data_word <= ram_rdata_q;
        BankRegs: read_data_word <= reg_rdata_q;
        BankFifo: read_data_word <= fifo_rdata_q;
        default:  read_data_word <= DATA_WIDTH'(UNMAPPED_READBACK);
      endcase
    end
  end

endmodule

// File: tb/tb_rpi_bus_banked_memory.sv
// Directed self-checking bench for rpi_bus_banked_memory; inputs change on the falling edge.
module tb_rpi_bus_banked_memory;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  write_strobe = '0;
  logic [31:0] write_data_word = '0;
  logic [15:0] address_word = '0;
  logic        read_complete = 1'b0;
  logic [31:0] read_data_word;
  logic [4:0]  fifo_count;
  logic        fifo_overflow, fifo_underflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  rpi_bus_banked_memory dut (
    .clock           (clock),
    .reset           (reset),
    .write_strobe    (write_strobe),
    .write_data_word (write_data_word),
    .address_word    (address_word),
    .read_complete   (read_complete),
    .read_data_word  (read_data_word),
    .fifo_count      (fifo_count),
    .fifo_overflow   (fifo_overflow),
    .fifo_underflow  (fifo_underflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] addr(input logic [1:0] bank, input logic [13:0] off);
    return {bank, off};
  endfunction

  task automatic bus_write(input logic [1:0] bank, input logic [13:0] off,
                           input logic [31:0] data);
    address_word    = addr(bank, off);
    write_data_word = data;
    write_strobe    = 4'b0001 << bank;
    @(posedge clock);
    @(negedge clock);
    write_strobe = '0;
  endtask

  task automatic bus_read_check(input string tag, input logic [1:0] bank,
                                input logic [13:0] off, input logic [31:0] exp);
    address_word = addr(bank, off);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq(tag, read_data_word, exp);
  endtask

  task automatic fifo_pop();
    address_word  = addr(2'd2, 14'd0);
    read_complete = 1'b1;
    @(posedge clock);
    @(negedge clock);
    read_complete = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check_eq("rst_rdata", read_data_word, 32'h0);
    check_eq("rst_count", 32'(fifo_count), 32'h0);
    check_eq("rst_sticky", {30'h0, fifo_underflow, fifo_overflow}, 32'h0);
    reset = 1'b1;
    @(negedge clock);

    // RAM write/read, write counter and offset aliasing
    bus_write(2'd0, 14'h05, 32'h1234_5678);
    bus_write(2'd0, 14'h06, 32'h0BAD_F00D);
    bus_read_check("ram_off5", 2'd0, 14'h05, 32'h1234_5678);
    bus_read_check("ram_off6", 2'd0, 14'h06, 32'h0BAD_F00D);
    bus_read_check("ram_alias", 2'd0, 14'h105, 32'h1234_5678);
    bus_read_check("wr_count2", 2'd1, 14'h3, 32'd2);

    // FIFO fall-through and pop
    bus_write(2'd2, 14'h0, 32'hA);
    bus_write(2'd2, 14'h0, 32'hB);
    bus_write(2'd2, 14'h0, 32'hC);
    bus_read_check("fifo_head_a", 2'd2, 14'h0, 32'hA);
    fifo_pop();
    bus_read_check("fifo_head_b", 2'd2, 14'h0, 32'hB);
    bus_read_check("status_cnt2", 2'd1, 14'h2, 32'h0000_0002);
    check_eq("port_cnt2", 32'(fifo_count), 32'd2);

    // Clear, then overfill
    bus_write(2'd1, 14'h1, 32'h1);
    check_eq("clr_cnt", 32'(fifo_count), 32'd0);
    bus_read_check("ctrl_reads0", 2'd1, 14'h1, 32'h0);
    bus_read_check("status_empty", 2'd1, 14'h2, 32'h0000_0020);
    for (int i = 0; i < 17; i++) bus_write(2'd2, 14'h0, 32'h100 + 32'(i));
    check_eq("full_cnt", 32'(fifo_count), 32'd16);
    check_eq("ovf_sticky", 32'(fifo_overflow), 32'd1);
    bus_read_check("status_full", 2'd1, 14'h2, 32'h0000_00D0);
    bus_read_check("full_head", 2'd2, 14'h0, 32'h100);
    bus_write(2'd1, 14'h1, 32'h1);
    check_eq("clr2_cnt", 32'(fifo_count), 32'd0);
    check_eq("clr2_sticky", {30'h0, fifo_underflow, fifo_overflow}, 32'h0);
    bus_read_check("empty_read0", 2'd2, 14'h0, 32'h0);

    // Underflow, then simultaneous push/pop
    fifo_pop();
    check_eq("unf_sticky", 32'(fifo_underflow), 32'd1);
    check_eq("unf_cnt", 32'(fifo_count), 32'd0);
    bus_read_check("status_unf", 2'd1, 14'h2, 32'h0000_0120);
    bus_write(2'd1, 14'h1, 32'h1);
    for (int i = 0; i < 3; i++) bus_write(2'd2, 14'h0, 32'h200 + 32'(i));
    address_word    = addr(2'd2, 14'h0);
    write_data_word = 32'h203;
    write_strobe    = 4'b0100;
    read_complete   = 1'b1;
    @(posedge clock);
    @(negedge clock);
    write_strobe  = '0;
    read_complete = 1'b0;
    check_eq("pushpop_cnt", 32'(fifo_count), 32'd3);
    bus_read_check("pushpop_head", 2'd2, 14'h0, 32'h201);

    // Unmapped bank, read-only status, scratch, unused offset
    bus_read_check("bank3_0", 2'd3, 14'h0, 32'hDEAD_BEEF);
    bus_read_check("bank3_x", 2'd3, 14'h1234, 32'hDEAD_BEEF);
    bus_write(2'd3, 14'h0, 32'h1111_1111);
    bus_write(2'd1, 14'h2, 32'hFFFF_FFFF);
    bus_read_check("status_ro", 2'd1, 14'h2, 32'h0000_0003);
    bus_write(2'd1, 14'h0, 32'hCAFE_F00D);
    bus_read_check("scratch", 2'd1, 14'h0, 32'hCAFE_F00D);
    bus_read_check("unused_off", 2'd1, 14'h5, 32'h0);

    // Checksum (control bit1 clears it first; ignored when not built)
    bus_write(2'd1, 14'h1, 32'h2);
    bus_write(2'd0, 14'h10, 32'hF0F0_F0F0);
    bus_write(2'd0, 14'h11, 32'h0F0F_0F0F);
`ifdef RPI_BUS_BANKED_MEMORY_WRITE_CHECKSUM_EN
    bus_read_check("checksum", 2'd1, 14'h4, 32'hFFFF_FFFF);
`else
    bus_read_check("checksum_off", 2'd1, 14'h4, 32'h0);
`endif
    bus_read_check("wr_count4", 2'd1, 14'h3, 32'd4);
    check_eq("ctrl2_no_clr", 32'(fifo_count), 32'd3);

    // Reset mid-stream
    bus_write(2'd2, 14'h0, 32'h204);
    bus_write(2'd2, 14'h0, 32'h205);
    check_eq("pre_rst_cnt", 32'(fifo_count), 32'd5);
    bus_read_check("pre_rst_scr", 2'd1, 14'h0, 32'hCAFE_F00D);
    #1 reset = 1'b0;
    #1;
    check_eq("async_rdata", read_data_word, 32'h0);
    check_eq("async_cnt", 32'(fifo_count), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    bus_read_check("post_rst_scr", 2'd1, 14'h0, 32'h0);
    bus_read_check("post_rst_wcnt", 2'd1, 14'h3, 32'h0);
    bus_read_check("ram_kept", 2'd0, 14'h05, 32'h1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
